// File: rtl/core_0_fetch_pkg.sv
// core_0_fetch_pkg: shared defaults for the instruction-fetch stage.
//   ADDR_W_DEF   - word-address width (instruction memory depth 256)
//   DATA_W_DEF   - instruction width
//   RESET_PC_DEF - first word address fetched after reset
//   INSTR_NOP    - canonical NOP encoding (addi x0, x0, 0), handy for benches
package core_0_fetch_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned RESET_PC_DEF = 0;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/core_0_fetch_buf.sv
// core_0_fetch_buf: 2-entry FIFO of {pc, instruction} between fetch and decode.
// Ports:
//   clock, reset       - clock and asynchronous active-high reset
//   i_push, i_pop      - enqueue / dequeue strobes (both allowed in one cycle)
//   i_flush            - empties the FIFO; wins over push and pop
//   i_push_pc/instr    - entry written on push
//   o_count            - number of valid entries (0..2)
//   o_head_pc/instr    - oldest entry; stale when o_count == 0
module core_0_fetch_buf #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_push_pc,
    input  logic [DATA_W-1:0] i_push_instr,
    output logic [1:0]        o_count,
    output logic [ADDR_W-1:0] o_head_pc,
    output logic [DATA_W-1:0] o_head_instr
);

    logic [ADDR_W-1:0] r_pc_mem    [2];
    logic [DATA_W-1:0] r_instr_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic w_push;
    logic w_pop;

    // Guard against misuse so pointers and count can never desynchronise.
    always_comb begin
        w_pop  = i_pop & (r_count != 2'd0);
        w_push = i_push & ((r_count != 2'd2) | w_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc_mem[0]    <= '0;
            r_pc_mem[1]    <= '0;
            r_instr_mem[0] <= '0;
            r_instr_mem[1] <= '0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wr_ptr]    <= i_push_pc;
                r_instr_mem[r_wr_ptr] <= i_push_instr;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_comb begin
        o_count      = r_count;
        o_head_pc    = r_pc_mem[r_rd_ptr];
        o_head_instr = r_instr_mem[r_rd_ptr];
    end

endmodule

// File: rtl/core_0_fetch.sv
// core_0_fetch: instruction-fetch stage feeding decode.
// Holds the PC, issues word addresses to a 1-cycle synchronous-read instruction
// memory, pairs each returned word with its PC and presents it over valid/ready.
// Ports:
//   clock, reset                - clock and asynchronous active-high reset
//   fetch_enable                - permits new fetch requests
//   redirect_valid, redirect_pc - taken branch/jump; squashes buffered and in-flight work
//   imem_address                - word address to instruction memory (= PC register)
//   imem_instruction            - memory data for the address sampled at the previous edge
//   out_valid, out_ready        - handshake to decode
//   out_instruction, out_pc     - head of the fetch buffer
module core_0_fetch
    import core_0_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [DATA_W-1:0] imem_instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instruction,
    output logic [ADDR_W-1:0] out_pc
);

    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_inflight;

    logic [1:0]        w_count;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [2:0]        w_credit_used;

    always_comb begin
        w_pop  = out_valid & out_ready;
        // A response landing in a redirect cycle belongs to the squashed stream.
        w_push = r_inflight & ~redirect_valid;
        // Slots committed after this edge: buffered + in flight - leaving now.
        // Issuing only while this is below 2 means the buffer can never overflow.
        w_credit_used = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue = fetch_enable & ~redirect_valid & (w_credit_used < 3'd2);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc       <= ResetPc;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 1'b1;  // wraps modulo 2^ADDR_W
            end
        end
    end

    core_0_fetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clock        (clock),
        .reset        (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .i_push_pc    (r_req_pc),
        .i_push_instr (imem_instruction),
        .o_count      (w_count),
        .o_head_pc    (out_pc),
        .o_head_instr (out_instruction)
    );

    always_comb begin
        imem_address = r_pc;
        out_valid    = (w_count != 2'd0);
    end

endmodule

// File: tb/tb_core_0_fetch.sv
// tb_core_0_fetch: directed bench for core_0_fetch with a 1-cycle synchronous
// instruction memory model holding mem[i] = 32'h1000_0000 + i.
module tb_core_0_fetch;

    logic        clock;
    logic        reset;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [7:0]  imem_address;
    logic [31:0] imem_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [7:0]  out_pc;

    logic [31:0] mem [256];

    int n_tests;
    int n_fail;

    core_0_fetch #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .RESET_PC (0)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_enable     (fetch_enable),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) imem_instruction <= mem[imem_address];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_head(input string tag, input int pc);
        logic [31:0] word;
        word = 32'h1000_0000 + 32'(pc);
        check_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, ".pc"}, {24'd0, out_pc}, 32'(pc));
        check_eq({tag, ".instr"}, out_instruction, word);
    endtask

    task automatic expect_empty(input string tag);
        check_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic expect_addr(input string tag, input int addr);
        check_eq({tag, ".addr"}, {24'd0, imem_address}, 32'(addr));
    endtask

    initial begin
        int wrap_seq [4];
        wrap_seq = '{32'hFE, 32'hFF, 32'h00, 32'h01};
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);

        reset          = 1'b1;
        fetch_enable   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        out_ready      = 1'b0;
        #2;
        expect_empty("rst");
        expect_addr("rst", 0);
        check_eq("rst.pc", {24'd0, out_pc}, 32'd0);
        check_eq("rst.instr", out_instruction, 32'd0);

        // Streaming from reset: issue at edge 0, first output after edge 1.
        fetch_enable = 1'b1;
        out_ready    = 1'b1;
        reset        = 1'b0;
        tick;
        expect_empty("e0");
        expect_addr("e0", 1);
        for (int k = 1; k <= 4; k++) begin
            tick;
            expect_head($sformatf("stream%0d", k), k - 1);
            expect_addr($sformatf("stream%0d", k), k + 1);
        end

        // Stall with pc 3 at the head: pc 4 arrives, then issue stops at pc 5.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            expect_head($sformatf("stall%0d", i), 3);
            expect_addr($sformatf("stall%0d", i), 5);
        end
        out_ready = 1'b1;
        for (int p = 4; p <= 7; p++) begin
            tick;
            expect_head($sformatf("drain%0d", p), p);
        end

        // Fill the buffer to two entries, then redirect to 0x40.
        out_ready = 1'b0;
        tick;
        expect_head("prefill", 7);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        tick;
        redirect_valid = 1'b0;
        expect_empty("redir40.r0");
        expect_addr("redir40.r0", 8'h40);
        tick;
        expect_empty("redir40.r1");
        expect_addr("redir40.r1", 8'h41);
        tick;
        expect_head("redir40.r2", 8'h40);
        tick;
        expect_head("redir40.r3", 8'h41);

        // Redirect to 0xFE in steady flow; PC wraps to 0x00.
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        tick;
        redirect_valid = 1'b0;
        expect_empty("redirFE.r0");
        tick;
        expect_empty("redirFE.r1");
        for (int i = 0; i < 4; i++) begin
            tick;
            expect_head($sformatf("wrap%0d", i), wrap_seq[i]);
        end
        expect_addr("wrap.end", 3);

        // fetch_enable low for 3 cycles: in-flight pc 2 still delivered.
        fetch_enable = 1'b0;
        tick;
        expect_head("fe_off0", 2);
        expect_addr("fe_off0", 3);
        tick;
        expect_empty("fe_off1");
        expect_addr("fe_off1", 3);
        tick;
        expect_empty("fe_off2");
        expect_addr("fe_off2", 3);
        fetch_enable = 1'b1;
        tick;
        expect_empty("fe_on0");
        expect_addr("fe_on0", 4);
        tick;
        expect_head("fe_on1", 3);
        tick;
        expect_head("fe_on2", 4);

        // Fill buffer, then assert reset between clock edges.
        out_ready = 1'b0;
        tick;
        tick;
        expect_head("full", 4);
        #3;
        reset = 1'b1;
        #1;
        expect_empty("async_rst");
        expect_addr("async_rst", 0);
        out_ready = 1'b1;
        tick;
        expect_empty("rst_hold");
        expect_addr("rst_hold", 0);
        #2;
        reset = 1'b0;
        tick;
        expect_empty("restart0");
        expect_addr("restart0", 1);
        for (int k = 0; k < 3; k++) begin
            tick;
            expect_head($sformatf("restart%0d", k + 1), k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
